// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side responder for the processor data/address bus.
// Services level-held memory read (MR) and memory write (MW) requests against a
// synchronous word-addressed RAM, with WAIT_STATES cycles between request capture
// and the single access cycle.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   mem_read     MR request, held until ready
//   mem_write    MW request, held until ready
//   address      word address
//   data_in      write data
//   data_out     read data (valid only while data_out_en is high)
//   data_out_en  databus drive enable for the top-level tri-state
//   ready        one-cycle completion pulse
//   error        one-cycle fault pulse, coincident with ready
//   busy         high whenever the responder is not idle
module mem_bus_responder #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DEPTH_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_en,
    output logic                  ready,
    output logic                  error,
    output logic                  busy
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;
    localparam int unsigned CntW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_STATES - 1);

    // One extra bit so BASE_ADDR + depth does not wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] RangeLo = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] RangeHi = RangeLo + (ADDR_WIDTH + 1)'(64'd1 << DEPTH_LOG2);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StHold} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    perr_q, perr_d;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    access_err;

    logic [DATA_WIDTH-1:0]   mem [Words];

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] ax;
        ax = {1'b0, a};
        return (ax >= RangeLo) && (ax < RangeHi);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] ram_index(input logic [ADDR_WIDTH-1:0] a);
        return DEPTH_LOG2'(a - BASE_ADDR);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        perr_d  = perr_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (mem_read || mem_write) begin
                    // A protocol error takes the same wait path so completion timing is
                    // uniform; it is handled as a read that returns zero.
                    perr_d  = mem_read && mem_write;
                    write_d = mem_write && !mem_read;
                    if (!(mem_read && mem_write)) begin
                        addr_d  = address;
                        wdata_d = data_in;
                    end
                    state_d = (WAIT_STATES > 0) ? StWait : StAccess;
                end
            end
            StWait: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAccess: state_d = StHold;
            StHold: begin
                // Wait for the requester to drop so a held request cannot re-trigger.
                if (!mem_read && !mem_write) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign access_err  = perr_q || !addr_in_range(addr_q);
    assign ready       = (state_q == StAccess);
    assign error       = ready && access_err;
    assign data_out_en = ready && !write_q;
    assign busy        = (state_q != StIdle);
    assign data_out    = data_out_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            perr_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            perr_q  <= perr_d;
            // Synchronous RAM read on the edge entering ACCESS; faults read as zero.
            if (state_d == StAccess && !write_d) begin
                data_out_q <= (perr_d || !addr_in_range(addr_d)) ? '0 : mem[ram_index(addr_d)];
            end
        end
    end

    // Commit on the edge ending ACCESS; a reset on that edge discards the write.
    always_ff @(posedge clock) begin
        if (!reset && state_q == StAccess && write_q && !access_err) begin
            mem[ram_index(addr_q)] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with two wait states and one
// with none, sharing clock and reset. Expected values are hand-computed constants.
module tb_mem_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        mr2, mw2, en2, rdy2, er2, bz2;
    logic [15:0] a2, d2, q2;
    logic        mr0, mw0, en0, rdy0, er0, bz0;
    logic [15:0] a0, d0, q0;

    mem_bus_responder #(.WAIT_STATES(2)) dut_ws2 (
        .clock(clk), .reset(rst), .mem_read(mr2), .mem_write(mw2), .address(a2),
        .data_in(d2), .data_out(q2), .data_out_en(en2), .ready(rdy2), .error(er2), .busy(bz2)
    );

    mem_bus_responder #(.WAIT_STATES(0)) dut_ws0 (
        .clock(clk), .reset(rst), .mem_read(mr0), .mem_write(mw0), .address(a0),
        .data_in(d0), .data_out(q0), .data_out_en(en0), .ready(rdy0), .error(er0), .busy(bz0)
    );

    // sel=0 targets the two-wait-state instance, sel=1 the zero-wait-state one.
    logic        sel;
    logic        o_rdy, o_en, o_err, o_busy;
    logic [15:0] o_dout;
    always_comb begin
        o_rdy  = sel ? rdy0 : rdy2;
        o_en   = sel ? en0  : en2;
        o_err  = sel ? er0  : er2;
        o_busy = sel ? bz0  : bz2;
        o_dout = sel ? q0   : q2;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d);
        if (sel) begin
            mr0 = rd; mw0 = wr; a0 = a; d0 = d;
        end else begin
            mr2 = rd; mw2 = wr; a2 = a; d2 = d;
        end
    endtask

    // Results of the last transaction.
    int          lat, extra, en_cnt;
    logic [15:0] dout;
    logic        en, err, bz_hold, bz_after;

    // Drive a request in cycle 0, find the ready pulse (lat = cycle index, -1 if none),
    // keep the request held for 'hold' more cycles, then release it.
    task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int hold);
        lat = -1; dout = '0; en = 1'b0; err = 1'b0;
        extra = 0; en_cnt = 0; bz_hold = 1'b1; bz_after = 1'b1;
        @(posedge clk); #1;
        set_req(rd, wr, a, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_en) en_cnt++;
            if (o_rdy) begin
                lat = i; dout = o_dout; en = o_en; err = o_err;
                break;
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (o_rdy) extra++;
            if (o_en) en_cnt++;
            bz_hold = bz_hold & o_busy;
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        if (o_rdy) extra++;
        if (o_en) en_cnt++;
        bz_hold = bz_hold & o_busy;
        @(negedge clk);
        if (o_rdy) extra++;
        if (o_en) en_cnt++;
        bz_after = o_busy;
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        mr2 = 0; mw2 = 0; a2 = 0; d2 = 0;
        mr0 = 0; mw0 = 0; a0 = 0; d0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy2", bz2, 1'b0);
        check("rst_ready2", rdy2, 1'b0);
        check("rst_err2", er2, 1'b0);
        check("rst_en2", en2, 1'b0);
        check("rst_dout2", q2, 16'h0000);
        check("rst_busy0", bz0, 1'b0);
        check("rst_dout0", q0, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Preload known contents through the bus.
        xact(1'b0, 1'b1, 16'h0000, 16'h5555, 0);
        xact(1'b0, 1'b1, 16'h0001, 16'h1111, 0);
        xact(1'b0, 1'b1, 16'h0002, 16'h0000, 0);

        // Write then read, two wait states.
        xact(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0);
        check("w5_lat", lat, 3);
        check("w5_en", en, 1'b0);
        check("w5_err", err, 1'b0);
        xact(1'b1, 1'b0, 16'h0005, 16'h0000, 0);
        check("r5_lat", lat, 3);
        check("r5_data", dout, 16'hBEEF);
        check("r5_en", en, 1'b1);
        check("r5_en_cycles", en_cnt, 1);
        check("r5_err", err, 1'b0);
        check("r5_idle_after", bz_after, 1'b0);

        // Request held well past ready: one pulse, busy until released.
        xact(1'b1, 1'b0, 16'h0005, 16'h0000, 10);
        check("held_lat", lat, 3);
        check("held_extra_ready", extra, 0);
        check("held_busy", bz_hold, 1'b1);
        check("held_idle_after", bz_after, 1'b0);

        // Out-of-range write must not alias onto word 0.
        xact(1'b0, 1'b1, 16'h0400, 16'h1234, 0);
        check("oor_w_lat", lat, 3);
        check("oor_w_err", err, 1'b1);
        xact(1'b1, 1'b0, 16'h0000, 16'h0000, 0);
        check("r0_data", dout, 16'h5555);
        check("r0_err", err, 1'b0);

        // Simultaneous MR+MW.
        xact(1'b1, 1'b1, 16'h0001, 16'h9999, 0);
        check("both_lat", lat, 3);
        check("both_err", err, 1'b1);
        xact(1'b1, 1'b0, 16'h0001, 16'h0000, 0);
        check("r1_data", dout, 16'h1111);

        // Reset in the first WAIT cycle of a write.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 16'h0002, 16'hAAAA);
        @(posedge clk); #1;
        check("midrst_busy_pre", o_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_ready", o_rdy, 1'b0);
        check("midrst_err", o_err, 1'b0);
        check("midrst_en", o_en, 1'b0);
        check("midrst_dout", o_dout, 16'h0000);
        xact(1'b1, 1'b0, 16'h0002, 16'h0000, 0);
        check("r2_lat", lat, 3);
        check("r2_data", dout, 16'h0000);

        // Zero wait states, last word of the window.
        sel = 1'b1;
        xact(1'b0, 1'b1, 16'h03FF, 16'hCAFE, 0);
        check("ws0_w_lat", lat, 1);
        check("ws0_w_err", err, 1'b0);
        xact(1'b1, 1'b0, 16'h03FF, 16'h0000, 0);
        check("ws0_r_lat", lat, 1);
        check("ws0_r_data", dout, 16'hCAFE);
        check("ws0_r_en", en, 1'b1);
        check("ws0_r_err", err, 1'b0);
        xact(1'b1, 1'b0, 16'h0400, 16'h0000, 0);
        check("ws0_oor_lat", lat, 1);
        check("ws0_oor_err", err, 1'b1);
        check("ws0_oor_data", dout, 16'h0000);
        check("ws0_oor_en", en, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
